// File: rtl/sca_trigger_gen.sv
// Side-channel capture-trigger generator: gated level or delayed/width pulse.
// Optional trigger event counter enabled by defining SCA_TRIG_CNT_EN.
module sca_trigger_gen #(
   parameter int NumSrc = 4,
   parameter int CntW   = 16
) (
   input  logic              clk_i,
   input  logic              rst_i,
   input  logic              sw_trig_i,
   input  logic [NumSrc-1:0] src_busy_i,
   input  logic [NumSrc-1:0] cfg_src_sel_i,
   input  logic [1:0]        cfg_mode_i,
   input  logic [CntW-1:0]   cfg_delay_i,
   input  logic [CntW-1:0]   cfg_width_i,
   input  logic              arm_i,
   output logic              trig_o,
   output logic              armed_o,
   output logic [15:0]       trig_cnt_o
);

   localparam logic [1:0] M_GATED = 2'd0;
   localparam logic [1:0] M_REARM = 2'd2;
   localparam logic [1:0] M_OFF   = 2'd3;

   localparam logic [1:0] S_IDLE  = 2'd0;
   localparam logic [1:0] S_ARMED = 2'd1;
   localparam logic [1:0] S_DELAY = 2'd2;
   localparam logic [1:0] S_PULSE = 2'd3;

   localparam logic [CntW-1:0] ONE = {{(CntW-1){1'b0}}, 1'b1};

   logic [1:0]      state_q, state_d;
   logic [1:0]      mode_q;
   logic [CntW-1:0] cnt_q, cnt_d;
   logic [CntW-1:0] wid_q, wid_d;
   logic            qual_q;
   logic            trig_q, trig_d;
   logic            qual, rise, mode_chg;
   logic [CntW-1:0] width_eff;

   // An empty source mask means the software trigger alone qualifies.
   assign qual = sw_trig_i &
                 ((cfg_src_sel_i == '0) | (|(src_busy_i & cfg_src_sel_i)));
   assign rise      = qual & ~qual_q;
   assign width_eff = (cfg_width_i == '0) ? ONE : cfg_width_i;
   assign mode_chg  = (cfg_mode_i != mode_q);

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      wid_d   = wid_q;
      trig_d  = 1'b0;
      if ((cfg_mode_i == M_GATED) || (cfg_mode_i == M_OFF)) begin
         state_d = S_IDLE;
         trig_d  = (cfg_mode_i == M_GATED) & qual;
      end else if ((state_q != S_IDLE) && mode_chg) begin
         state_d = S_IDLE;
         cnt_d   = '0;
      end else begin
         unique case (state_q)
            S_IDLE: begin
               if (arm_i) state_d = S_ARMED;
            end
            S_ARMED: begin
               if (rise) begin
                  wid_d = width_eff;
                  if (cfg_delay_i == '0) begin
                     state_d = S_PULSE;
                     cnt_d   = width_eff;
                  end else begin
                     state_d = S_DELAY;
                     cnt_d   = cfg_delay_i;
                  end
               end
            end
            S_DELAY: begin
               if (cnt_q == ONE) begin
                  state_d = S_PULSE;
                  cnt_d   = wid_q;
               end else begin
                  cnt_d = cnt_q - ONE;
               end
            end
            S_PULSE: begin
               if (cnt_q == ONE) begin
                  state_d = (cfg_mode_i == M_REARM) ? S_ARMED : S_IDLE;
                  cnt_d   = '0;
               end else begin
                  cnt_d = cnt_q - ONE;
               end
            end
            default: state_d = S_IDLE;
         endcase
         trig_d = (state_d == S_PULSE);
      end
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q <= S_IDLE;
         mode_q  <= M_GATED;
         cnt_q   <= '0;
         wid_q   <= '0;
         qual_q  <= 1'b0;
         trig_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         mode_q  <= cfg_mode_i;
         cnt_q   <= cnt_d;
         wid_q   <= wid_d;
         qual_q  <= qual;
         trig_q  <= trig_d;
      end
   end

   assign trig_o  = trig_q;
   assign armed_o = (state_q == S_ARMED);

`ifdef SCA_TRIG_CNT_EN
   logic [15:0] tcnt_q;

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         tcnt_q <= '0;
      end else if (trig_d && !trig_q && (tcnt_q != 16'hFFFF)) begin
         tcnt_q <= tcnt_q + 16'd1;
      end
   end

   assign trig_cnt_o = tcnt_q;
`else
   assign trig_cnt_o = 16'h0000;
`endif

endmodule

// File: doc/sca_trigger_gen.md
# sca_trigger_gen

Capture-trigger generator for side-channel analysis on FPGA targets. It qualifies a software-controlled trigger with busy indications from up to `NumSrc` crypto cores and drives a single capture-trigger output toward the scope or capture board. It sits between the core's GPIO output path and the trigger pad. Two styles are supported: level gating, or a one-shot/re-armable pulse with programmable delay and width.

## Interface
- `NumSrc`, default 4: number of busy-source inputs (1..32).
- `CntW`, default 16: width of the delay and width counters.

- `clk_i`  in  1  sole clock; all logic in this domain.
- `rst_i`  in  1  synchronous, active-high reset.
- `sw_trig_i`  in  1  software trigger level (GPIO output from core).
- `src_busy_i`  in  NumSrc  per-source busy (core not idle).
- `cfg_src_sel_i`  in  NumSrc  source enable mask.
- `cfg_mode_i`  in  2  0 GATED, 1 ONESHOT, 2 REARM, 3 OFF.
- `cfg_delay_i`  in  CntW  cycles from qualifying edge to pulse start.
- `cfg_width_i`  in  CntW  pulse width in cycles; 0 is treated as 1.
- `arm_i`  in  1  single-cycle arm request for ONESHOT/REARM.
- `trig_o`  out  1  capture trigger, registered.
- `armed_o`  out  1  high while FSM is in ARMED.
- `trig_cnt_o`  out  16  trigger event count (see Configuration).

## Operation
- Qualifier: `qual = sw_trig_i & |(src_busy_i & cfg_src_sel_i)`. If `cfg_src_sel_i == 0`, then `qual = sw_trig_i`. `qual_q` is the registered copy, and `rise = qual & ~qual_q`.
- GATED (mode 0): `trig_o <= qual` every cycle. The FSM is held in IDLE.
- OFF (mode 3): `trig_o = 0`. The FSM is held in IDLE.
- FSM for modes 1/2 has four states: IDLE, ARMED, DELAY, PULSE.
  - IDLE: `arm_i` moves to ARMED.
  - ARMED: `rise` latches `cfg_delay_i`/`cfg_width_i` into internal registers. With latched delay 0 it goes to PULSE, otherwise to DELAY.
  - DELAY: down-counter from the latched delay; on reaching 1 it goes to PULSE.
  - PULSE: `trig_o = 1` for max(width,1) cycles. ONESHOT then goes to IDLE; REARM goes to ARMED.
- `arm_i` is ignored outside IDLE.
- `rise` is ignored outside ARMED. There is no retrigger or extension during DELAY or PULSE.
- `cfg_delay_i`/`cfg_width_i` changes after latching have no effect on the event in flight.
- A change of `cfg_mode_i` while the FSM is not in IDLE returns it to IDLE next cycle with `trig_o = 0`. Any pulse in progress is truncated.
- Counter widths: delay/width counters are `CntW` bits and do not wrap. Maximum delay/width is 2^CntW−1.

## Timing
- Reset: `trig_o=0`, `armed_o=0`, `trig_cnt_o=0`, FSM in IDLE, `qual_q=0`, counters 0.
- GATED latency: `trig_o` follows `qual` with exactly 1 cycle delay.
- Pulse latency: `rise` in cycle t gives the first `trig_o=1` in cycle t+1+delay.
- Pulse duration: `trig_o` stays high for exactly max(width,1) consecutive cycles.
- REARM: `armed_o` is high the cycle after the last pulse cycle. A `rise` in that cycle is accepted.
- `rst_i` mid-pulse: `trig_o=0` on the next edge.
- `rise` coincident with `arm_i` in IDLE is not captured; the FSM enters ARMED only.

## Configuration
- Macro `SCA_TRIG_CNT_EN`.
- Defined: `trig_cnt_o` increments by 1 on each cycle where `trig_o` rises 0→1, in any mode. It saturates at 16'hFFFF and is cleared only by `rst_i`.
- Undefined: the counter logic is absent and `trig_cnt_o` is tied to 16'h0000.

## Test plan
- GATED, sel=4'b0010, `sw_trig_i=1`, src1 busy for cycles 10–19 -> `trig_o` high for cycles 11–20 only. src0 busy has no effect.
- ONESHOT, delay=5, width=3, arm, then `rise` at cycle 20 -> `trig_o` high in cycles 26–28. A second `rise` at cycle 40 gives no pulse, and `armed_o=0` after cycle 28.
- REARM, delay=0, width=0, three `rise` events 10 cycles apart -> three 1-cycle pulses, each 1 cycle after its `rise`. `trig_cnt_o=3` when the macro is defined, 0 when it is not.
- ONESHOT, delay=100. Change `cfg_delay_i` to 2 during DELAY -> pulse still starts 101 cycles after `rise`. Change `cfg_mode_i` to OFF during PULSE -> `trig_o=0` next cycle and FSM in IDLE.
- Assert `rst_i` for 1 cycle during PULSE with width=50 -> `trig_o`, `armed_o`, `trig_cnt_o` all 0 next cycle. No pulse follows until a new `arm_i` and `rise`.
